iiitb_apb_wait_slave: RTL
=========================

Name: iiitb_apb_wait_slave

Overview:
- APB2 completer, directly downstream of the iiitb_apb bridge: consumes PSEL/PENABLE/PWRITE/PADDR/PWDATA from one slave-select leg and returns PRDATA/PREADY/PSLVERR.
- Backs an 8-bit register file with a programmable number of wait states and out-of-range error signalling.
- Used to exercise the bridge's wait-state and error paths.

Parameters:
- ADDR_W, 8, width of PADDR seen by the slave (bridge strips the slave-select bit).
- DATA_W, 8, data width.
- DEPTH, 64, number of storage words; valid addresses are 0..DEPTH-1.
- WAIT_CYCLES, 2, wait states inserted in every access phase (0..15).

Ports:
- PCLK  in  1  clock, all state on rising edge.
- PRESETn  in  1  asynchronous, active-low reset.
- PSEL  in  1  slave select from bridge.
- PENABLE  in  1  access-phase strobe.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDR_W  word address.
- PWDATA  in  DATA_W  write data.
- PRDATA  out  DATA_W  read data, registered.
- PREADY  out  1  transfer-complete, registered.
- PSLVERR  out  1  error response, registered, valid only with PREADY.

Behaviour:
- Reset (PRESETn=0, asynchronous): state=IDLE, PREADY=0, PSLVERR=0, PRDATA=0, wait counter=0, all DEPTH words cleared to 0. Applies immediately, including mid-transfer; an in-flight write is dropped.
- FSM states: IDLE, ACCESS.
- IDLE:
  - On an edge with PSEL=1, PENABLE=0 (setup phase): latch PADDR, PWRITE, PWDATA; compute err = (PADDR >= DEPTH); load cnt = WAIT_CYCLES; set PREADY <= (WAIT_CYCLES==0); go ACCESS.
  - On any other edge: stay in IDLE.
- ACCESS, PSEL=1 and PENABLE=1:
  - If PREADY=1 at the edge, the transfer completes: commit the write to mem[latched addr] if write and !err; clear PREADY, PSLVERR; go IDLE.
  - Otherwise: cnt <= cnt-1; PREADY <= (cnt==1).
- PREADY rise edge:
  - Read: PRDATA <= err ? 0 : mem[latched addr].
  - PSLVERR <= err.
  - Write: PRDATA unchanged.
- Access phase lasts exactly WAIT_CYCLES+1 cycles.
- PRDATA holds its value until the next read completion.
- Abort: in ACCESS with PSEL=0 → IDLE; no write; PREADY=0, PSLVERR=0.
- Back-to-back: the setup phase in the cycle after completion is accepted from IDLE with no bubble beyond the APB setup cycle.
- Address and write data used are the setup-edge latched values; changes to PADDR/PWDATA during ACCESS are ignored.
- PENABLE=1 while in IDLE, without a prior setup, is ignored.

Optional Feature:
- Macro IIITB_APB_SLV_RO_REGION_EN.
- Defined: addresses DEPTH*3/4..DEPTH-1 (48..63 at default) are read-only. A write there completes with PSLVERR=1 and no update; reads are normal. Reset still clears the region.
- Undefined: the whole range is writable and err depends only on the range check.

Decomposition:
- Package iiitb_apb_pkg: FSM state enum (IDLE, ACCESS), default ADDR_W/DATA_W constants, RO region start expression.
- Sub-module iiitb_apb_regfile: DEPTH x DATA_W storage with async clear, one synchronous write port and one combinational read port. The slave top holds the FSM, counter and response registers.

Test Plan:
- Reset with PSEL=1 mid-setup → PREADY=0, PSLVERR=0, PRDATA=0x00. Any address read after release returns 0x00.
- Write addr 0x05 data 0x0A, WAIT_CYCLES=2 → PREADY=1 only in the 3rd access cycle, PSLVERR=0. Subsequent read of 0x05 → PRDATA=0x0A when PREADY=1.
- Back-to-back writes addr i, data 2*i for i=0..7, then reads of 0..7 → PRDATA = 0x00,0x02,…,0x0E. Each access phase is exactly 3 cycles.
- Write addr 0x50 (≥64) data 0x33 → PSLVERR=1 with PREADY. Read 0x50 → PRDATA=0x00, PSLVERR=1. Read 0x10 afterwards shows no corruption.
- Abort: write 0x05 data 0xFF, drop PSEL after first access cycle → FSM to IDLE, no write. Read 0x05 → 0x0A.
- With IIITB_APB_SLV_RO_REGION_EN: write 0x30 data 0x77 → PSLVERR=1, read 0x30 → 0x00. Without the macro: same write gives PSLVERR=0 and read returns 0x77. Separately, PRESETn pulsed during ACCESS → PREADY=0 immediately.

Source files
------------

// File: rtl/iiitb_apb_pkg.sv
// -----------------------------------------------------------------------------
// iiitb_apb_pkg
// Shared definitions for the APB wait-state completer:
//   - state_t        : completer FSM states (IDLE, ACCESS)
//   - APB_ADDR_W     : default PADDR width seen by the completer
//   - APB_DATA_W     : default data width
//   - ro_start()     : first word of the optional read-only region
// -----------------------------------------------------------------------------
package iiitb_apb_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

   localparam int APB_ADDR_W = 8;
   localparam int APB_DATA_W = 8;

   // The read-only region covers the top quarter of the storage.
   function automatic int ro_start(input int depth);
      return (depth * 3) / 4;
   endfunction

endpackage

// File: rtl/iiitb_apb_regfile.sv
// -----------------------------------------------------------------------------
// iiitb_apb_regfile
// DEPTH x DATA_W storage, cleared by the asynchronous reset, with one
// synchronous write port and one combinational read port.
// Ports:
//   clk      in   clock
//   rst_n    in   asynchronous active-low clear of every word
//   i_we     in   write enable
//   i_waddr  in   write word address (must be < DEPTH to take effect)
//   i_wdata  in   write data
//   i_raddr  in   read word address (out-of-range reads return 0)
//   o_rdata  out  read data (combinational)
// -----------------------------------------------------------------------------
module iiitb_apb_regfile #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8,
   parameter int DEPTH  = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] w_words [DEPTH];

   // One register per word so the whole array can be cleared asynchronously.
   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_word
         logic [DATA_W-1:0] r_word;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_word <= '0;
            end else if (i_we && (i_waddr == ADDR_W'(gi))) begin
               r_word <= i_wdata;
            end
         end

         assign w_words[gi] = r_word;
      end
   endgenerate

   always_comb begin
      o_rdata = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (i_raddr == ADDR_W'(i)) begin
            o_rdata = w_words[i];
         end
      end
   end

endmodule

// File: rtl/iiitb_apb_wait_slave.sv
// -----------------------------------------------------------------------------
// iiitb_apb_wait_slave
// APB2 completer backing a register file, inserting WAIT_CYCLES wait states in
// every access phase and flagging out-of-range addresses with PSLVERR.
// Optional build macro IIITB_APB_SLV_RO_REGION_EN: the top quarter of the
// storage becomes read-only (writes there complete with PSLVERR=1, no update).
// Ports:
//   PCLK     in   clock, all state on rising edge
//   PRESETn  in   asynchronous active-low reset
//   PSEL     in   slave select
//   PENABLE  in   access-phase strobe
//   PWRITE   in   1 = write, 0 = read
//   PADDR    in   word address
//   PWDATA   in   write data
//   PRDATA   out  read data, registered, held until the next read completes
//   PREADY   out  transfer complete, registered
//   PSLVERR  out  error response, registered, valid with PREADY
// -----------------------------------------------------------------------------
module iiitb_apb_wait_slave
   import iiitb_apb_pkg::*;
#(
   parameter int ADDR_W      = APB_ADDR_W,
   parameter int DATA_W      = APB_DATA_W,
   parameter int DEPTH       = 64,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              PCLK,
   input  logic              PRESETn,
   input  logic              PSEL,
   input  logic              PENABLE,
   input  logic              PWRITE,
   input  logic [ADDR_W-1:0] PADDR,
   input  logic [DATA_W-1:0] PWDATA,
   output logic [DATA_W-1:0] PRDATA,
   output logic              PREADY,
   output logic              PSLVERR
);

   state_t            r_state,  w_state_nxt;
   logic [ADDR_W-1:0] r_addr,   w_addr_nxt;
   logic [DATA_W-1:0] r_wdata,  w_wdata_nxt;
   logic              r_write,  w_write_nxt;
   logic              r_err,    w_err_nxt;
   logic [3:0]        r_cnt,    w_cnt_nxt;
   logic              r_pready, w_pready_nxt;
   logic              r_slverr, w_slverr_nxt;
   logic [DATA_W-1:0] r_prdata, w_prdata_nxt;

   logic              w_setup_err;
   logic              w_mem_we;
   logic [ADDR_W-1:0] w_rd_addr;
   logic [DATA_W-1:0] w_mem_rdata;
   logic              w_rise;
   logic              w_rise_err;
   logic              w_rise_write;

   // Error decision is made once, at the setup edge, from the live bus.
`ifdef IIITB_APB_SLV_RO_REGION_EN
   assign w_setup_err = (int'(PADDR) >= DEPTH) ||
                        (PWRITE && (int'(PADDR) >= ro_start(DEPTH)));
`else
   assign w_setup_err = (int'(PADDR) >= DEPTH);
`endif

   // With zero wait states PREADY rises on the setup edge itself, so the read
   // must look at the live address while idle.
   assign w_rd_addr = (r_state == IDLE) ? PADDR : r_addr;

   iiitb_apb_regfile #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_regfile (
      .clk     (PCLK),
      .rst_n   (PRESETn),
      .i_we    (w_mem_we),
      .i_waddr (r_addr),
      .i_wdata (r_wdata),
      .i_raddr (w_rd_addr),
      .o_rdata (w_mem_rdata)
   );

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_state  <= IDLE;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_write  <= 1'b0;
         r_err    <= 1'b0;
         r_cnt    <= '0;
         r_pready <= 1'b0;
         r_slverr <= 1'b0;
         r_prdata <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_addr   <= w_addr_nxt;
         r_wdata  <= w_wdata_nxt;
         r_write  <= w_write_nxt;
         r_err    <= w_err_nxt;
         r_cnt    <= w_cnt_nxt;
         r_pready <= w_pready_nxt;
         r_slverr <= w_slverr_nxt;
         r_prdata <= w_prdata_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_addr_nxt   = r_addr;
      w_wdata_nxt  = r_wdata;
      w_write_nxt  = r_write;
      w_err_nxt    = r_err;
      w_cnt_nxt    = r_cnt;
      w_pready_nxt = r_pready;
      w_slverr_nxt = r_slverr;
      w_prdata_nxt = r_prdata;
      w_mem_we     = 1'b0;
      w_rise       = 1'b0;
      w_rise_err   = r_err;
      w_rise_write = r_write;

      case (r_state)
         IDLE: begin
            // Only a genuine setup phase starts a transfer.
            if (PSEL && !PENABLE) begin
               w_addr_nxt   = PADDR;
               w_wdata_nxt  = PWDATA;
               w_write_nxt  = PWRITE;
               w_err_nxt    = w_setup_err;
               w_cnt_nxt    = 4'(WAIT_CYCLES);
               w_state_nxt  = ACCESS;
               if (WAIT_CYCLES == 0) begin
                  w_pready_nxt = 1'b1;
                  w_rise       = 1'b1;
                  w_rise_err   = w_setup_err;
                  w_rise_write = PWRITE;
               end
            end
         end
         ACCESS: begin
            if (!PSEL) begin
               // Abort: drop the transfer without touching storage.
               w_state_nxt  = IDLE;
               w_pready_nxt = 1'b0;
               w_slverr_nxt = 1'b0;
            end else if (PENABLE) begin
               if (r_pready) begin
                  w_mem_we     = r_write && !r_err;
                  w_pready_nxt = 1'b0;
                  w_slverr_nxt = 1'b0;
                  w_state_nxt  = IDLE;
               end else begin
                  w_cnt_nxt = r_cnt - 4'd1;
                  if (r_cnt == 4'd1) begin
                     w_pready_nxt = 1'b1;
                     w_rise       = 1'b1;
                  end
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase

      // Response is captured on the edge where PREADY goes high.
      if (w_rise) begin
         w_slverr_nxt = w_rise_err;
         if (!w_rise_write) begin
            w_prdata_nxt = w_rise_err ? '0 : w_mem_rdata;
         end
      end
   end

   assign PRDATA  = r_prdata;
   assign PREADY  = r_pready;
   assign PSLVERR = r_slverr;

endmodule
